// File: rtl/regfile_scoreboard.sv
// Register file with two write ports, two combinational read ports, write-through
// bypass and a per-register busy scoreboard that flags operands still in flight.
module regfile_scoreboard #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [AW-1:0]         SA,
    input  logic [AW-1:0]         SB,
    output logic [DW-1:0]         DataA,
    output logic [DW-1:0]         DataB,
    input  logic                  WE0,
    input  logic [AW-1:0]         WA0,
    input  logic [DW-1:0]         WD0,
    input  logic                  WE1,
    input  logic [AW-1:0]         WA1,
    input  logic [DW-1:0]         WD1,
    input  logic                  BSET,
    input  logic [AW-1:0]         BADDR,
    output logic                  STALL_A,
    output logic                  STALL_B,
    output logic [(1<<AW)-1:0]    BUSY,
    output logic                  CONFLICT
);

    localparam int N  = 1 << AW;
    localparam bit ZR = (ZERO_R0 != 0);

    logic [DW-1:0] regs_q [N];
    logic [N-1:0]  busy_q;
    logic [N-1:0]  busy_d;
    logic          conflict_q;
    logic          collision;
    logic [N-1:0]  wr0Hit;
    logic [N-1:0]  wr1Hit;

    always_comb begin
        wr0Hit    = '0;
        wr1Hit    = '0;
        busy_d    = '0;
        collision = WE0 && WE1 && (WA0 == WA1);
        for (int i = 0; i < N; i++) begin
            wr0Hit[i] = WE0 && (WA0 == AW'(i));
            wr1Hit[i] = WE1 && (WA1 == AW'(i));
            // A completing write retires the pending mark unless a new producer claims it now
            busy_d[i] = (busy_q[i] && !(wr0Hit[i] || wr1Hit[i])) || (BSET && (BADDR == AW'(i)));
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!(ZR && i == 0)) begin
                    if (wr1Hit[i]) begin
                        regs_q[i] <= WD1;
                    end else if (wr0Hit[i]) begin
                        regs_q[i] <= WD0;
                    end
                end
            end
            busy_q     <= busy_d;
            conflict_q <= collision;
        end
    end

    // Port 1 bypass is applied last so it overrides port 0; hardwired r0 overrides everything
    always_comb begin
        DataA = regs_q[SA];
        if (WE0 && (WA0 == SA)) DataA = WD0;
        if (WE1 && (WA1 == SA)) DataA = WD1;
        if (ZR && (SA == '0)) DataA = '0;

        DataB = regs_q[SB];
        if (WE0 && (WA0 == SB)) DataB = WD0;
        if (WE1 && (WA1 == SB)) DataB = WD1;
        if (ZR && (SB == '0)) DataB = '0;

        STALL_A = busy_q[SA] && !(WE0 && (WA0 == SA)) && !(WE1 && (WA1 == SA));
        STALL_B = busy_q[SB] && !(WE0 && (WA0 == SB)) && !(WE1 && (WA1 == SB));
    end

    assign BUSY     = busy_q;
    assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one instance with a normal r0 and one with a hardwired
// r0 share the same stimulus and are checked against a behavioural model.
module tb_regfile_scoreboard;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] sa, sb, wa0, wa1, baddr;
    logic [7:0] wd0, wd1;
    logic       we0, we1, bset;

    logic [7:0] dataA0, dataB0, dataA1, dataB1, busy0, busy1;
    logic       stallA0, stallB0, stallA1, stallB1, conflict0, conflict1;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] mem  [2][8] = '{default: '0};
    logic [7:0] busyM[2]    = '{default: '0};
    logic       confM[2]    = '{default: '0};

    regfile_scoreboard #(.DW(8), .AW(3), .ZERO_R0(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .SA(sa), .SB(sb), .DataA(dataA0), .DataB(dataB0),
        .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
        .BSET(bset), .BADDR(baddr), .STALL_A(stallA0), .STALL_B(stallB0),
        .BUSY(busy0), .CONFLICT(conflict0)
    );

    regfile_scoreboard #(.DW(8), .AW(3), .ZERO_R0(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .SA(sa), .SB(sb), .DataA(dataA1), .DataB(dataB1),
        .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
        .BSET(bset), .BADDR(baddr), .STALL_A(stallA1), .STALL_B(stallB1),
        .BUSY(busy1), .CONFLICT(conflict1)
    );

    always #5 CLK = ~CLK;

    // Model: port 0 is applied first and port 1 afterwards, so port 1 naturally wins a collision
    always @(posedge CLK) begin
        for (int z = 0; z < 2; z++) begin
            if (RESET) begin
                for (int a = 0; a < 8; a++) mem[z][a] = 8'h00;
                busyM[z] = 8'h00;
                confM[z] = 1'b0;
            end else begin
                confM[z] = we0 && we1 && (wa0 == wa1);
                if (we0 && !(z == 1 && wa0 == 3'd0)) mem[z][wa0] = wd0;
                if (we1 && !(z == 1 && wa1 == 3'd0)) mem[z][wa1] = wd1;
                if (we0) busyM[z][wa0] = 1'b0;
                if (we1) busyM[z][wa1] = 1'b0;
                if (bset && !(z == 1 && baddr == 3'd0)) busyM[z][baddr] = 1'b1;
            end
        end
    end

    function automatic logic [7:0] expData(input int z, input logic [2:0] a);
        if (z == 1 && a == 3'd0) return 8'h00;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return mem[z][a];
    endfunction

    function automatic logic expStall(input int z, input logic [2:0] a);
        return busyM[z][a] && !(we0 && wa0 == a) && !(we1 && wa1 == a);
    endfunction

    task automatic setIdle();
        RESET = 1'b0; we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
        wa0 = 3'd0; wa1 = 3'd0; baddr = 3'd0; wd0 = 8'h00; wd1 = 8'h00;
        sa = 3'd0; sb = 3'd0;
    endtask

    task automatic test_reset();
        @(negedge CLK); setIdle(); RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK); RESET = 1'b0;
        for (int a = 0; a < 8; a++) begin
            sa = 3'(a); sb = 3'(7 - a);
            #1;
            checkCount++;
            if (dataA0 !== 8'h00 || dataB0 !== 8'h00 || dataA1 !== 8'h00 || dataB1 !== 8'h00)
                $display("FAIL reset_data a=%0d: got %h %h %h %h expected 00", a, dataA0, dataB0, dataA1, dataB1);
            else passCount++;
        end
        checkCount++;
        if (busy0 !== 8'h00 || busy1 !== 8'h00 || conflict0 !== 1'b0 || conflict1 !== 1'b0 ||
            stallA0 !== 1'b0 || stallB0 !== 1'b0)
            $display("FAIL reset_flags: got busy %h %h conf %b %b stall %b %b expected 00 00 0 0 0 0",
                     busy0, busy1, conflict0, conflict1, stallA0, stallB0);
        else passCount++;
    endtask

    task automatic test_bypass();
        @(negedge CLK); setIdle(); we0 = 1'b1; wa0 = 3'd3; wd0 = 8'h5A; sa = 3'd3;
        #1;
        checkCount++;
        if (dataA0 !== 8'h5A) $display("FAIL bypass_same_cycle: got %h expected 5a", dataA0);
        else passCount++;
        @(negedge CLK); we0 = 1'b0;
        #1;
        checkCount++;
        if (dataA0 !== 8'h5A) $display("FAIL bypass_from_array: got %h expected 5a", dataA0);
        else passCount++;
    endtask

    task automatic test_collision();
        @(negedge CLK); setIdle();
        we0 = 1'b1; wa0 = 3'd5; wd0 = 8'h11; we1 = 1'b1; wa1 = 3'd5; wd1 = 8'h22; sa = 3'd5;
        #1;
        checkCount++;
        if (dataA0 !== 8'h22) $display("FAIL collision_bypass_priority: got %h expected 22", dataA0);
        else passCount++;
        @(negedge CLK); setIdle(); sa = 3'd5;
        #1;
        checkCount++;
        if (dataA0 !== 8'h22 || conflict0 !== 1'b1)
            $display("FAIL collision_write: got data %h conflict %b expected 22 1", dataA0, conflict0);
        else passCount++;
        @(negedge CLK);
        #1;
        checkCount++;
        if (conflict0 !== 1'b0) $display("FAIL collision_pulse_end: got %b expected 0", conflict0);
        else passCount++;
    endtask

    task automatic test_busy();
        @(negedge CLK); setIdle(); bset = 1'b1; baddr = 3'd2;
        @(negedge CLK); setIdle(); sa = 3'd2;
        #1;
        checkCount++;
        if (busy0 !== 8'h04 || stallA0 !== 1'b1)
            $display("FAIL busy_set: got busy %h stall %b expected 04 1", busy0, stallA0);
        else passCount++;
        @(negedge CLK); we1 = 1'b1; wa1 = 3'd2; wd1 = 8'h7F;
        #1;
        checkCount++;
        if (stallA0 !== 1'b0 || dataA0 !== 8'h7F)
            $display("FAIL busy_write_release: got stall %b data %h expected 0 7f", stallA0, dataA0);
        else passCount++;
        @(negedge CLK); setIdle();
        #1;
        checkCount++;
        if (busy0 !== 8'h00) $display("FAIL busy_cleared: got %h expected 00", busy0);
        else passCount++;
    endtask

    task automatic test_set_wins();
        @(negedge CLK); setIdle(); bset = 1'b1; baddr = 3'd6; we0 = 1'b1; wa0 = 3'd6; wd0 = 8'h33;
        @(negedge CLK); setIdle(); sa = 3'd6;
        #1;
        checkCount++;
        if (dataA0 !== 8'h33 || busy0[6] !== 1'b1 || stallA0 !== 1'b1)
            $display("FAIL set_wins: got data %h busy6 %b stall %b expected 33 1 1", dataA0, busy0[6], stallA0);
        else passCount++;
    endtask

    task automatic test_zero_r0();
        @(negedge CLK); setIdle(); we0 = 1'b1; wa0 = 3'd0; wd0 = 8'hFF; bset = 1'b1; baddr = 3'd0; sa = 3'd0;
        #1;
        checkCount++;
        if (dataA1 !== 8'h00 || stallA1 !== 1'b0 || dataA0 !== 8'hFF)
            $display("FAIL zero_r0_bypass: got r0z %h stall %b normal %h expected 00 0 ff", dataA1, stallA1, dataA0);
        else passCount++;
        @(negedge CLK); setIdle(); sa = 3'd0;
        #1;
        checkCount++;
        if (dataA1 !== 8'h00 || busy1[0] !== 1'b0 || stallA1 !== 1'b0 || busy0[0] !== 1'b1 || dataA0 !== 8'hFF)
            $display("FAIL zero_r0_after: got r0z %h busy0 %b stall %b normal busy0 %b data %h expected 00 0 0 1 ff",
                     dataA1, busy1[0], stallA1, busy0[0], dataA0);
        else passCount++;
        @(negedge CLK); setIdle(); RESET = 1'b1; we1 = 1'b1; wa1 = 3'd4; wd1 = 8'h44;
        @(negedge CLK); setIdle(); sa = 3'd4;
        #1;
        checkCount++;
        if (dataA0 !== 8'h00 || dataA1 !== 8'h00 || busy0 !== 8'h00)
            $display("FAIL reset_priority: got %h %h busy %h expected 00 00 00", dataA0, dataA1, busy0);
        else passCount++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            RESET = ($urandom_range(31) == 0);
            we0   = $urandom_range(1);
            we1   = $urandom_range(1);
            bset  = ($urandom_range(3) == 0);
            wa0   = 3'($urandom_range(7));
            wa1   = ($urandom_range(3) == 0) ? wa0 : 3'($urandom_range(7));
            baddr = ($urandom_range(3) == 0) ? wa0 : 3'($urandom_range(7));
            wd0   = 8'($urandom);
            wd1   = 8'($urandom);
            sa    = 3'($urandom_range(7));
            sb    = ($urandom_range(3) == 0) ? sa : 3'($urandom_range(7));
            #1;
            for (int z = 0; z < 2; z++) begin
                logic [7:0] gA, gB, gBusy;
                logic       gSa, gSb, gConf;
                gA    = (z == 0) ? dataA0 : dataA1;
                gB    = (z == 0) ? dataB0 : dataB1;
                gBusy = (z == 0) ? busy0 : busy1;
                gSa   = (z == 0) ? stallA0 : stallA1;
                gSb   = (z == 0) ? stallB0 : stallB1;
                gConf = (z == 0) ? conflict0 : conflict1;
                checkCount++;
                if (gA !== expData(z, sa) || gB !== expData(z, sb))
                    $display("FAIL rand_data c=%0d z=%0d: got %h %h expected %h %h",
                             c, z, gA, gB, expData(z, sa), expData(z, sb));
                else passCount++;
                checkCount++;
                if (gSa !== expStall(z, sa) || gSb !== expStall(z, sb))
                    $display("FAIL rand_stall c=%0d z=%0d: got %b %b expected %b %b",
                             c, z, gSa, gSb, expStall(z, sa), expStall(z, sb));
                else passCount++;
                checkCount++;
                if (gBusy !== busyM[z] || gConf !== confM[z])
                    $display("FAIL rand_flags c=%0d z=%0d: got busy %h conf %b expected %h %b",
                             c, z, gBusy, gConf, busyM[z], confM[z]);
                else passCount++;
            end
        end
    endtask

    initial begin
        setIdle();
        RESET = 1'b1;
        test_reset();
        test_bypass();
        test_collision();
        test_busy();
        test_set_wins();
        test_zero_r0();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DW, default 8: data width in bits.
REQ-002 Parameter AW, default 3: address width; depth N = 2^AW registers.
REQ-003 Parameter ZERO_R0, default 0: 1 makes register 0 hardwired to zero.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RESET  in  1  reset, synchronous, active-high.
REQ-006 SA, SB  in  AW  read addresses, ports A and B.
REQ-007 DataA, DataB  out  DW  read data, ports A and B.
REQ-008 WE0, WA0, WD0  in  1/AW/DW  write port 0: enable, address, data.
REQ-009 WE1, WA1, WD1  in  1/AW/DW  write port 1: enable, address, data.
REQ-010 BSET, BADDR  in  1/AW  mark register BADDR busy (pending result).
REQ-011 STALL_A, STALL_B  out  1  operand at SA / SB not yet available.
REQ-012 BUSY  out  N  registered busy bit per register, bit i = register i.
REQ-013 CONFLICT  out  1  registered one-cycle pulse: both write ports targeted the same address.

Function
REQ-014 Write: on the rising edge, each enabled port writes its data to its address; no enabled port leaves the register unchanged.
REQ-015 Same-address collision (WE0 & WE1 & WA0==WA1): port 1 data is written, port 0 is dropped, and CONFLICT is 1 for exactly the following cycle.
REQ-016 Read is combinational, zero-cycle latency, from the register array.
REQ-017 Write-through bypass: if a write port is enabled to the read address in the same cycle, DataA/DataB return that write data; port 1 has priority over port 0.
REQ-018 Both read ports are independent; SA==SB is legal and returns identical data.
REQ-019 Busy set: BSET sets BUSY[BADDR] on the rising edge.
REQ-020 Busy clear: any enabled write (either port) to address i clears BUSY[i] on the rising edge.
REQ-021 Simultaneous BSET and write to the same address: set wins (BUSY stays/becomes 1); the data is still written.
REQ-022 STALL_A = BUSY[SA] and no enabled write to SA this cycle; STALL_B likewise for SB; purely combinational.
REQ-023 ZERO_R0=1: reads of address 0 return 0, including bypass; writes to 0 are ignored; BUSY[0] is never set; STALL for address 0 is 0; a port-0/port-1 collision at address 0 still pulses CONFLICT.
REQ-024 ZERO_R0=0: register 0 behaves as any other register.
REQ-025 Address arithmetic is exact AW bits; no out-of-range addresses exist.

Reset
REQ-026 RESET high at a rising edge clears all N registers to 0, BUSY to all zeros, CONFLICT to 0.
REQ-027 RESET takes priority over writes, BSET and collisions in the same cycle.
REQ-028 During RESET, reads stay combinational: array contents before the edge, 0 after; bypass remains active.

Verification
REQ-029 Reset, then read all 8 addresses (defaults) -> DataA=DataB=0x00, BUSY=0x00, STALL_A=STALL_B=0, CONFLICT=0.
REQ-030 WE0=1, WA0=3, WD0=0x5A, SA=3, same cycle -> DataA=0x5A (bypass); next cycle with WE0=0 -> DataA=0x5A from array.
REQ-031 WE0=1/WA0=5/WD0=0x11 with WE1=1/WA1=5/WD1=0x22 -> next cycle register 5 reads 0x22, CONFLICT=1 for one cycle then 0.
REQ-032 BSET, BADDR=2; next cycle SA=2 -> BUSY=0x04, STALL_A=1; then WE1=1, WA1=2, WD1=0x7F -> STALL_A=0 that cycle, DataA=0x7F, BUSY=0x00 after the edge.
REQ-033 BSET, BADDR=6 with WE0=1/WA0=6/WD0=0x33 same cycle -> register 6=0x33, BUSY[6]=1.
REQ-034 ZERO_R0=1: WE0=1/WA0=0/WD0=0xFF and BSET/BADDR=0 -> DataA at SA=0 is 0x00 in the same and next cycle, BUSY[0]=0, STALL_A=0; then RESET asserted with WE1=1/WA1=4/WD1=0x44 -> register 4=0x00 after the edge.
